// File: rtl/kmeans_pkg.sv
// Shared constants, state encoding, point type and distance helper for the K-means engine.
package kmeans_pkg;

    localparam int unsigned K      = 4;
    localparam int unsigned N      = 4096;
    localparam int unsigned W      = 8;
    localparam int unsigned SUM_W  = 20;
    localparam int unsigned CNT_W  = 13;
    localparam int unsigned ADDR_W = 12;
    localparam int unsigned DIST_W = W + 1;
    localparam int unsigned IDX_W  = 2;
    localparam int unsigned Q_W    = W;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_LOAD   = 3'd1;
    localparam logic [2:0] ST_ASSIGN = 3'd2;
    localparam logic [2:0] ST_DIVIDE = 3'd3;
    localparam logic [2:0] ST_CHECK  = 3'd4;
    localparam logic [2:0] ST_OUTPUT = 3'd5;

    typedef struct packed {
        logic [W-1:0] x;
        logic [W-1:0] y;
    } point_t;

    function automatic logic [DIST_W-1:0] manhattan(input point_t a, input point_t b);
        logic [W-1:0] dx;
        logic [W-1:0] dy;
        dx = (a.x >= b.x) ? a.x - b.x : b.x - a.x;
        dy = (a.y >= b.y) ? a.y - b.y : b.y - a.y;
        return DIST_W'(dx) + DIST_W'(dy);
    endfunction

endpackage

// File: rtl/kmeans_div.sv
// Restoring divider: one load cycle then eight quotient-bit cycles; result valid with done_c.
module kmeans_div
    import kmeans_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [SUM_W-1:0] dividend,
    input  logic [CNT_W-1:0] divisor,
    output logic [Q_W-1:0]   quotient_c,
    output logic             done_c
);

    logic [SUM_W-1:0]     rem_r;
    logic [CNT_W-1:0]     div_r;
    logic [Q_W-1:0]       q_r;
    logic [2:0]           step_r;
    logic                 busy_r;
    logic [SUM_W+Q_W-1:0] trial;
    logic                 ge;

    // The quotient always fits Q_W bits, so only Q_W shifted trial subtractions are needed.
    always_comb begin
        trial      = (SUM_W+Q_W)'(div_r) << step_r;
        ge         = (SUM_W+Q_W)'(rem_r) >= trial;
        done_c     = busy_r && (step_r == 3'd0);
        quotient_c = q_r | Q_W'(ge);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rem_r  <= '0;
            div_r  <= '0;
            q_r    <= '0;
            step_r <= '0;
            busy_r <= 1'b0;
        end else if (start) begin
            rem_r  <= dividend;
            div_r  <= divisor;
            q_r    <= '0;
            step_r <= 3'(Q_W - 1);
            busy_r <= 1'b1;
        end else if (busy_r) begin
            if (ge) rem_r <= rem_r - SUM_W'(trial);
            q_r[step_r] <= ge;
            if (step_r == 3'd0) busy_r <= 1'b0;
            else                step_r <= step_r - 3'd1;
        end
    end

endmodule

// File: rtl/kmeans_core.sv
// K-means engine: loads centroids and points, iterates Manhattan assignment and
// floor-mean update until the centroids stop moving, then streams them out.
module kmeans_core
    import kmeans_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    input  logic [2*W-1:0] in_data,
    output logic           out_valid,
    output logic [2*W-1:0] out_data
);

    logic [2:0]        state_r, state_nxt;
    point_t            cur_r [K];
    point_t            new_r [K];
    logic [SUM_W-1:0]  sum_x_r [K];
    logic [SUM_W-1:0]  sum_y_r [K];
    logic [CNT_W-1:0]  cnt_r [K];
    point_t            mem_r [N];
    logic [CNT_W-1:0]  in_cnt_r, asg_cnt_r;
    logic              rd_en, rd_vld_r, sel_vld_r, mem_we;
    logic [ADDR_W-1:0] rd_addr, mem_addr;
    point_t            rd_pt_r, sel_pt_r;
    logic [IDX_W-1:0]  sel_idx_r, near_idx, div_c;
    logic [DIST_W-1:0] best, d;
    logic [3:0]        slot_r;
    logic [2:0]        dk_r, out_idx_r;
    logic              last_word, all_zero, changed, div_start, div_done;
    logic [SUM_W-1:0]  dividend;
    logic [CNT_W-1:0]  divisor;
    logic [Q_W-1:0]    div_q;

    always_comb begin
        last_word = in_valid && (in_cnt_r == CNT_W'(K + N - 1));
        all_zero  = 1'b1;
        changed   = 1'b0;
        for (int j = 0; j < K; j++) begin
            if (cur_r[j] != '0)       all_zero = 1'b0;
            if (new_r[j] != cur_r[j]) changed  = 1'b1;
        end
        mem_we    = (state_r == ST_LOAD) && in_valid && (in_cnt_r >= CNT_W'(K));
        mem_addr  = ADDR_W'(in_cnt_r - CNT_W'(K));
        rd_en     = (state_r == ST_ASSIGN) && (asg_cnt_r < CNT_W'(N));
        rd_addr   = ADDR_W'(asg_cnt_r);
        div_start = (state_r == ST_DIVIDE) && (slot_r == 4'd0);
        div_c     = dk_r[IDX_W:1];
        dividend  = dk_r[0] ? sum_y_r[div_c] : sum_x_r[div_c];
        divisor   = cnt_r[div_c];
    end

    // Nearest centroid; strict less-than keeps the lowest index on ties.
    always_comb begin
        near_idx = '0;
        d        = '0;
        best     = manhattan(cur_r[0], rd_pt_r);
        for (int j = 1; j < K; j++) begin
            d = manhattan(cur_r[j], rd_pt_r);
            if (d < best) begin
                best     = d;
                near_idx = IDX_W'(j);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) mem_r[mem_addr] <= in_data;
        if (rd_en)  rd_pt_r <= mem_r[rd_addr];
    end

    kmeans_div u_div (
        .clk        (clk),
        .rst        (rst),
        .start      (div_start),
        .dividend   (dividend),
        .divisor    (divisor),
        .quotient_c (div_q),
        .done_c     (div_done)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_r <= ST_IDLE;
        else     state_r <= state_nxt;
    end

    always_comb begin
        state_nxt = state_r;
        case (state_r)
            ST_IDLE:   if (in_valid) state_nxt = ST_LOAD;
            ST_LOAD:   if (last_word) state_nxt = all_zero ? ST_OUTPUT : ST_ASSIGN;
            ST_ASSIGN: if (asg_cnt_r == CNT_W'(N + 1)) state_nxt = ST_DIVIDE;
            ST_DIVIDE: if (div_done && (dk_r == 3'(2*K - 1))) state_nxt = ST_CHECK;
            ST_CHECK:  state_nxt = changed ? ST_ASSIGN : ST_OUTPUT;
            ST_OUTPUT: if (out_idx_r == 3'(K)) state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int j = 0; j < K; j++) begin
                cur_r[j]   <= '0;
                new_r[j]   <= '0;
                sum_x_r[j] <= '0;
                sum_y_r[j] <= '0;
                cnt_r[j]   <= '0;
            end
            in_cnt_r  <= '0;
            asg_cnt_r <= '0;
            rd_vld_r  <= 1'b0;
            sel_vld_r <= 1'b0;
            sel_pt_r  <= '0;
            sel_idx_r <= '0;
            slot_r    <= '0;
            dk_r      <= '0;
            out_idx_r <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            rd_vld_r  <= rd_en;
            sel_vld_r <= rd_vld_r;
            if (rd_vld_r) begin
                sel_pt_r  <= rd_pt_r;
                sel_idx_r <= near_idx;
            end
            case (state_r)
                ST_IDLE: if (in_valid) begin
                    cur_r[0] <= in_data;
                    in_cnt_r <= CNT_W'(1);
                end
                ST_LOAD: if (in_valid) begin
                    if (in_cnt_r < CNT_W'(K)) cur_r[IDX_W'(in_cnt_r)] <= in_data;
                    in_cnt_r <= in_cnt_r + CNT_W'(1);
                end
                ST_ASSIGN: begin
                    asg_cnt_r <= asg_cnt_r + CNT_W'(1);
                    slot_r    <= '0;
                    dk_r      <= '0;
                    if (sel_vld_r) begin
                        sum_x_r[sel_idx_r] <= sum_x_r[sel_idx_r] + SUM_W'(sel_pt_r.x);
                        sum_y_r[sel_idx_r] <= sum_y_r[sel_idx_r] + SUM_W'(sel_pt_r.y);
                        cnt_r[sel_idx_r]   <= cnt_r[sel_idx_r] + CNT_W'(1);
                    end
                end
                ST_DIVIDE: begin
                    if (div_done) begin
                        slot_r <= '0;
                        dk_r   <= dk_r + 3'd1;
                        // An empty cluster keeps its centroid.
                        if (dk_r[0]) new_r[div_c].y <= (divisor == '0) ? cur_r[div_c].y : div_q;
                        else         new_r[div_c].x <= (divisor == '0) ? cur_r[div_c].x : div_q;
                    end else begin
                        slot_r <= slot_r + 4'd1;
                    end
                end
                ST_CHECK: begin
                    for (int j = 0; j < K; j++) cur_r[j] <= new_r[j];
                end
                ST_OUTPUT: begin
                    if (out_idx_r == 3'(K)) begin
                        out_valid <= 1'b0;
                        out_data  <= '0;
                    end else begin
                        out_data  <= cur_r[IDX_W'(out_idx_r)];
                        out_idx_r <= out_idx_r + 3'd1;
                    end
                end
                default: ;
            endcase
            if ((state_nxt == ST_ASSIGN) && (state_r != ST_ASSIGN)) begin
                asg_cnt_r <= '0;
                for (int j = 0; j < K; j++) begin
                    sum_x_r[j] <= '0;
                    sum_y_r[j] <= '0;
                    cnt_r[j]   <= '0;
                end
            end
            // On a converged CHECK cur already equals new, so cur[0] is the final value.
            if ((state_nxt == ST_OUTPUT) && (state_r != ST_OUTPUT)) begin
                out_valid <= 1'b1;
                out_data  <= cur_r[0];
                out_idx_r <= 3'd1;
            end
        end
    end

endmodule

// File: tb/tb_kmeans_core.sv
// Bench for kmeans_core: directed and randomized data sets checked against a behavioural K-means model.
module tb_kmeans_core;
    import kmeans_pkg::*;

    localparam int NI   = int'(N);
    localparam int KI   = int'(K);
    localparam int ITER = NI + 75;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [15:0] in_data = '0;
    logic        out_valid;
    logic [15:0] out_data;

    kmeans_core dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_data  (out_data)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int px [NI];
    int py [NI];
    int cx [KI];
    int cy [KI];
    int ex [KI];
    int ey [KI];
    int exp_iter;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] expv);
        checks++;
        assert (got === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, expv);
        end
    endtask

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    // Plain K-means: Manhattan nearest (lowest index on ties), floor mean, stop when nothing moves.
    task automatic model();
        int  sx [KI];
        int  sy [KI];
        int  cn [KI];
        int  best, bd, dd, nx, ny;
        bit  moved, zero;
        zero = 1'b1;
        for (int j = 0; j < KI; j++) begin
            ex[j] = cx[j];
            ey[j] = cy[j];
            if (cx[j] != 0 || cy[j] != 0) zero = 1'b0;
        end
        exp_iter = 0;
        if (zero) return;
        do begin
            for (int j = 0; j < KI; j++) begin
                sx[j] = 0; sy[j] = 0; cn[j] = 0;
            end
            for (int i = 0; i < NI; i++) begin
                best = 0;
                bd   = -1;
                for (int j = 0; j < KI; j++) begin
                    dd = iabs(ex[j] - px[i]) + iabs(ey[j] - py[i]);
                    if (bd < 0 || dd < bd) begin
                        bd   = dd;
                        best = j;
                    end
                end
                sx[best] += px[i];
                sy[best] += py[i];
                cn[best] += 1;
            end
            moved = 1'b0;
            for (int j = 0; j < KI; j++) begin
                if (cn[j] != 0) begin
                    nx = sx[j] / cn[j];
                    ny = sy[j] / cn[j];
                    if (nx != ex[j] || ny != ey[j]) moved = 1'b1;
                    ex[j] = nx;
                    ey[j] = ny;
                end
            end
            exp_iter++;
        end while (moved && exp_iter < 20);
    endtask

    task automatic set_cents(input int x0, y0, x1, y1, x2, y2, x3, y3);
        cx[0] = x0; cy[0] = y0; cx[1] = x1; cy[1] = y1;
        cx[2] = x2; cy[2] = y2; cx[3] = x3; cy[3] = y3;
    endtask

    task automatic shuffle();
        int j, t;
        for (int i = NI - 1; i > 0; i--) begin
            j = int'($urandom_range(0, i));
            t = px[i]; px[i] = px[j]; px[j] = t;
            t = py[i]; py[i] = py[j]; py[j] = t;
        end
    endtask

    task automatic send(output int ovl);
        ovl = 0;
        for (int i = 0; i < KI + NI; i++) begin
            @(negedge clk);
            if (out_valid) ovl++;
            in_valid = 1'b1;
            in_data  = (i < KI) ? {8'(cx[i]), 8'(cy[i])} : {8'(px[i - KI]), 8'(py[i - KI])};
        end
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = '0;
    endtask

    task automatic run_case(input string tag);
        int lat, bad, ovl;
        bit seen;
        model();
        send(ovl);
        lat  = 1;
        bad  = 0;
        seen = out_valid;
        while (!seen && lat < 20 * ITER) begin
            if (out_data !== 16'h0) bad++;
            @(negedge clk);
            lat++;
            seen = out_valid;
        end
        chk({tag, "/latency"}, 32'(lat), 32'(exp_iter * ITER + 1));
        for (int k = 0; k < KI; k++) begin
            chk($sformatf("%s/valid%0d", tag, k), 32'(out_valid), 32'd1);
            chk($sformatf("%s/cent%0d", tag, k), 32'(out_data), 32'({8'(ex[k]), 8'(ey[k])}));
            @(negedge clk);
        end
        chk({tag, "/valid_after"}, 32'(out_valid), 32'd0);
        chk({tag, "/data_after"}, 32'(out_data), 32'd0);
        chk({tag, "/data_idle"}, 32'(bad), 32'd0);
        chk({tag, "/overlap"}, 32'(ovl), 32'd0);
        repeat (3) @(negedge clk);
    endtask

    task automatic fill_quadrants();
        for (int i = 0; i < NI; i++) begin
            px[i] = (i % 4 < 2) ? 10 : 240;
            py[i] = (i % 2 == 0) ? 10 : 240;
        end
        shuffle();
        set_cents(0, 0, 0, 255, 255, 0, 255, 255);
    endtask

    initial begin
        int ovl, hits;
        @(negedge clk);
        chk("reset/out_valid", 32'(out_valid), 32'd0);
        chk("reset/out_data", 32'(out_data), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("post_reset/out_valid", 32'(out_valid), 32'd0);

        for (int i = 0; i < NI; i++) begin px[i] = 10; py[i] = 20; end
        set_cents(0, 0, 50, 50, 100, 100, 200, 200);
        run_case("single");

        for (int i = 0; i < NI; i++) begin
            px[i] = int'($urandom_range(0, 255));
            py[i] = int'($urandom_range(0, 255));
        end
        set_cents(0, 0, 0, 0, 0, 0, 0, 0);
        run_case("all_zero");

        for (int i = 0; i < NI; i++) begin px[i] = 50; py[i] = 0; end
        set_cents(0, 0, 100, 0, 255, 255, 255, 0);
        run_case("tie");

        fill_quadrants();
        run_case("quadrants");

        for (int i = 0; i < NI; i++) begin
            px[i] = (i < NI / 2) ? 0 : 3;
            py[i] = (i < NI / 2) ? 0 : 1;
        end
        shuffle();
        set_cents(1, 1, 255, 255, 254, 255, 255, 254);
        run_case("floor_empty");

        // Reset while the engine is part-way through its first ASSIGN pass.
        fill_quadrants();
        send(ovl);
        hits = 0;
        repeat (100) begin
            @(negedge clk);
            if (out_valid) hits++;
        end
        rst = 1'b1;
        @(negedge clk);
        if (out_valid) hits++;
        @(negedge clk);
        rst = 1'b0;
        repeat (ITER + 200) begin
            @(negedge clk);
            if (out_valid) hits++;
        end
        chk("mid_reset/out_valid", 32'(hits), 32'd0);
        run_case("after_reset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
